pd_block_nios2e_cpu_debug_cmd_bridge: RTL and testbench
=======================================================

// Module: pd_block_nios2e_cpu_debug_cmd_bridge
// PURPOSE
//  Parametrised sysclk-side debug command bridge for the Nios II debug slave.
//  - Takes virtual-JTAG update-IR / update-DR levels from the TCK domain and synchronises them into clk.
//  - Queues {IR, DR} commands in a small FIFO.
//  - Releases commands through a valid/ready handshake as per-channel take_action / take_no_action pulses.
//  - Generalises the fixed 2-bit-IR / 38-bit-DR sysclk stage to N channels, with buffering and overflow reporting.
// PARAMETERS
//  IR_W        2   IR width; channel count NCH = 2**IR_W
//  DR_W        38  data register (sr/jdo) width
//  ACT_BIT     35  DR bit selecting take_action (1) or take_no_action (0); must be < DR_W
//  SYNC_STAGES 2   synchroniser flops per crossing level (>=2)
//  FIFO_DEPTH  4   command FIFO entries, power of two, >=2
// PORTS
//  clk           in   1       system clock
//  reset         in   1       synchronous, active-high reset
//  vs_uir        in   1       update-IR level, TCK domain (async to clk)
//  vs_udr        in   1       update-DR level, TCK domain (async to clk)
//  ir_in         in   IR_W    virtual IR; stable >= SYNC_STAGES+2 clk cycles after vs_uir rises
//  sr            in   DR_W    JTAG shift register; stable >= SYNC_STAGES+2 clk cycles after vs_udr rises
//  cmd_ready     in   1       consumer accepts the current command
//  overflow_clr  in   1       clears sticky overflow
//  cmd_valid     out  1       command presented on jdo/cmd_ch
//  cmd_ch        out  IR_W    channel (IR) of the presented command
//  jdo           out  DR_W    DR payload of the presented/last accepted command
//  take_action   out  NCH     one-hot 1-cycle pulse on accept when jdo[ACT_BIT]=1
//  take_no_action out NCH     one-hot 1-cycle pulse on accept when jdo[ACT_BIT]=0
//  fifo_level    out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  overflow      out  1       sticky: a DR update was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; ir_q = 0.
//    Sync chains and edge-history flops reset to 1, so a level already high at reset release does not pulse.
//  - Sync: vs_uir and vs_udr each pass through SYNC_STAGES flops.
//    A rising-edge detect (sync & ~hist) gives a 1-cycle uir_p / udr_p.
//  - uir_p: ir_q <= ir_in.
//  - udr_p: push {ir_q, sr} into the FIFO.
//    If the FIFO is full and not popping this cycle: drop the entry and set overflow.
//  - Same-cycle uir_p and udr_p: push uses the OLD ir_q; ir_q updates afterwards.
//  - Full with simultaneous pop and push: the push is accepted and the level is unchanged.
//  - Output stage FSM:
//    - IDLE: FIFO non-empty -> pop into the output register, go to VALID (cmd_valid=1 next cycle).
//    - VALID: cmd_valid & cmd_ready -> pulse take_action[cmd_ch] or take_no_action[cmd_ch] in the SAME cycle, based on jdo[ACT_BIT].
//      - If the FIFO is non-empty: pop the next entry the same cycle and stay in VALID (back-to-back, 1 cmd/cycle).
//      - Else: go to IDLE and drop cmd_valid.
//  - jdo and cmd_ch hold their values after accept until the next pop.
//  - The pulse vectors are never non-zero outside an accept cycle. At most one bit across both vectors is set per cycle.
//  - Latency: first clk edge sampling vs_udr=1 is cycle 0; udr_p at cycle SYNC_STAGES; FIFO write at cycle SYNC_STAGES+1; cmd_valid at SYNC_STAGES+2 (4 with defaults) when the FIFO is empty.
//  - Overflow: overflow_clr and a new drop in the same cycle -> overflow stays 1 (set wins).
//  - Mid-operation reset: FIFO, output register and pending commands are discarded. No pulse occurs in the reset cycle or the cycle after.
//  - vs_udr pulses shorter than SYNC_STAGES+1 clk periods are not guaranteed to be seen; the TCK-side protocol guarantees this.
// STRUCTURE
//  - Package nios_dbg_pkg: typedef dbg_cmd_t {ch[IR_W], dr[DR_W]}, default ACT_BIT, and localparam NCH.
//  - Sub-module nios_dbg_cmd_fifo: synchronous FIFO (wr/rd/full/empty/level) with registered pointers.
//    The wrap bit is an extra pointer MSB.
//  - Top contains the synchronisers, edge detect, ir_q, the output FSM and the overflow logic.
// TESTING
//  1. Single cmd: ir_in=2 via uir; sr[35]=1, sr=0x8_0000_1234 via udr; cmd_ready=1 -> cmd_valid at cycle 4.
//     jdo=0x8_0000_1234, cmd_ch=2, take_action=4'b0100 for 1 cycle.
//  2. No-action path: ir=1, sr[35]=0 -> take_no_action=4'b0010, take_action=0.
//  3. Backpressure/overflow: cmd_ready=0, 6 udr updates, DEPTH=4 -> fifo_level=4 with 1 held in the output register, 1 dropped, overflow=1.
//     Then cmd_ready=1 -> 5 commands in order on consecutive cycles.
//     overflow_clr clears overflow, except when coincident with a drop.
//  4. Same-cycle uir/udr edges with old ir=0, new ir=3 -> command has cmd_ch=0; the next udr yields cmd_ch=3.
//  5. Reset release with vs_udr held high -> no cmd_valid.
//     Reset asserted while VALID with 2 queued -> all outputs 0, fifo_level=0, and no pulses for 2 cycles after.

Source files
------------

// File: rtl/nios_dbg_pkg.sv
// rtl/nios_dbg_pkg.sv - shared types and default widths for the Nios II debug command bridge
package nios_dbg_pkg;

    localparam int DBG_IR_W    = 2;
    localparam int DBG_DR_W    = 38;
    localparam int DBG_ACT_BIT = 35;
    localparam int DBG_NCH     = 2 ** DBG_IR_W;

    typedef struct packed {
        logic [DBG_IR_W-1:0] ch;
        logic [DBG_DR_W-1:0] dr;
    } dbg_cmd_t;

    typedef enum logic {
        OUT_IDLE,
        OUT_VALID
    } out_state_t;

endpackage

// File: rtl/nios_dbg_cmd_fifo.sv
// rtl/nios_dbg_cmd_fifo.sv - synchronous command FIFO with wrap-bit pointers
module nios_dbg_cmd_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_wr;
    logic         do_rd;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || rd_en);
    assign do_rd = rd_en && !empty;

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/pd_block_nios2e_cpu_debug_cmd_bridge.sv
// rtl/pd_block_nios2e_cpu_debug_cmd_bridge.sv - sysclk-side debug command bridge: sync, queue, release as action pulses
module pd_block_nios2e_cpu_debug_cmd_bridge
    import nios_dbg_pkg::*;
#(
    parameter int IR_W        = DBG_IR_W,
    parameter int DR_W        = DBG_DR_W,
    parameter int ACT_BIT     = DBG_ACT_BIT,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            vs_uir,
    input  logic                            vs_udr,
    input  logic [IR_W-1:0]                 ir_in,
    input  logic [DR_W-1:0]                 sr,
    input  logic                            cmd_ready,
    input  logic                            overflow_clr,
    output logic                            cmd_valid,
    output logic [IR_W-1:0]                 cmd_ch,
    output logic [DR_W-1:0]                 jdo,
    output logic [2**IR_W-1:0]              take_action,
    output logic [2**IR_W-1:0]              take_no_action,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow
);

    localparam int NCH = 2 ** IR_W;

    typedef struct packed {
        logic [IR_W-1:0] ch;
        logic [DR_W-1:0] dr;
    } cmd_t;

    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] udr_sync;
    logic                   uir_hist;
    logic                   udr_hist;
    logic                   uir_p;
    logic                   udr_p;
    logic [IR_W-1:0]        ir_q;

    cmd_t                   wr_cmd;
    cmd_t                   rd_cmd;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   accept;
    logic [NCH-1:0]         ch_onehot;

    out_state_t             state;
    out_state_t             next_state;

    // Chains and history reset high so a level already asserted at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            uir_sync <= '1;
            udr_sync <= '1;
            uir_hist <= 1'b1;
            udr_hist <= 1'b1;
            uir_p    <= 1'b0;
            udr_p    <= 1'b0;
        end else begin
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_hist <= uir_sync[SYNC_STAGES-1];
            udr_hist <= udr_sync[SYNC_STAGES-1];
            uir_p    <= uir_sync[SYNC_STAGES-1] & ~uir_hist;
            udr_p    <= udr_sync[SYNC_STAGES-1] & ~udr_hist;
        end
    end

    // The push below samples ir_q before this update, so a coincident IR edge affects only later commands.
    always_ff @(posedge clk) begin
        if (reset)      ir_q <= '0;
        else if (uir_p) ir_q <= ir_in;
    end

    assign wr_cmd = '{ch: ir_q, dr: sr};
    assign push   = udr_p && (!fifo_full || pop);
    assign drop   = udr_p && fifo_full && !pop;

    nios_dbg_cmd_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (wr_cmd),
        .rd_en   (pop),
        .rd_data (rd_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= OUT_IDLE;
        else       state <= next_state;
    end

    assign cmd_valid = (state == OUT_VALID) && !reset;
    assign ch_onehot = NCH'(1) << cmd_ch;

    always_comb begin
        next_state     = state;
        pop            = 1'b0;
        accept         = (state == OUT_VALID) && cmd_ready && !reset;
        take_action    = '0;
        take_no_action = '0;
        case (state)
            OUT_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = OUT_VALID;
                end
            end
            OUT_VALID: begin
                if (accept) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             next_state = OUT_IDLE;
                end
            end
            default: next_state = OUT_IDLE;
        endcase
        if (accept) begin
            if (jdo[ACT_BIT]) take_action    = ch_onehot;
            else              take_no_action = ch_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ch <= '0;
            jdo    <= '0;
        end else if (pop) begin
            cmd_ch <= rd_cmd.ch;
            jdo    <= rd_cmd.dr;
        end
    end

    // A fresh drop outranks a coincident clear so no lost command goes unreported.
    always_ff @(posedge clk) begin
        if (reset)             overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (overflow_clr) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_pd_block_nios2e_cpu_debug_cmd_bridge.sv
// tb/tb_pd_block_nios2e_cpu_debug_cmd_bridge.sv - self-checking bench for the debug command bridge
module tb_pd_block_nios2e_cpu_debug_cmd_bridge;
    import nios_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vs_uir = 1'b0;
    logic        vs_udr = 1'b0;
    logic [1:0]  ir_in = '0;
    logic [37:0] sr = '0;
    logic        cmd_ready = 1'b0;
    logic        overflow_clr = 1'b0;
    logic        cmd_valid;
    logic [1:0]  cmd_ch;
    logic [37:0] jdo;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic [2:0]  fifo_level;
    logic        overflow;

    always #5 clk = ~clk;

    pd_block_nios2e_cpu_debug_cmd_bridge dut (
        .clk            (clk),
        .reset          (reset),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_ready      (cmd_ready),
        .overflow_clr   (overflow_clr),
        .cmd_valid      (cmd_valid),
        .cmd_ch         (cmd_ch),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .fifo_level     (fifo_level),
        .overflow       (overflow)
    );

    int          checks = 0;
    int          errors = 0;
    dbg_cmd_t    model_q[$];
    logic [1:0]  ir_model = '0;
    bit          mon_en = 1'b0;
    bit          rand_ready = 1'b0;
    int          acc_cnt = 0;
    logic [3:0]  last_ta, last_tna;
    logic [1:0]  last_ch;
    logic [37:0] last_jdo;
    dbg_cmd_t    m_e;
    logic [3:0]  m_eta, m_etn;

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] sr;
        logic [3:0]  ta;
        logic [3:0]  tna;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_uir(input logic [1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        step(4);
        vs_uir = 1'b0;
        step(4);
        ir_model = ir;
    endtask

    // sig: 0 none, 1 pulse cmd_ready in the FIFO-write cycle, 2 pulse overflow_clr in that cycle
    task automatic send_udr(input logic [37:0] v, input bit expect_push, input int sig);
        sr     = v;
        vs_udr = 1'b1;
        if (expect_push) model_q.push_back('{ch: ir_model, dr: v});
        step(3);
        if (sig == 1) cmd_ready = 1'b1;
        if (sig == 2) overflow_clr = 1'b1;
        step(1);
        if (sig == 1) cmd_ready = 1'b0;
        if (sig == 2) overflow_clr = 1'b0;
        vs_udr = 1'b0;
        step(4);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 80 && model_q.size() != 0; i++) step(1);
        chk(name, 64'(model_q.size()), 0);
    endtask

    // Scoreboard: every accept must match the next expected command; pulses only on accepts.
    always @(negedge clk) begin
        if (mon_en) begin
            m_eta = '0;
            m_etn = '0;
            if (!reset && cmd_valid && cmd_ready) begin
                acc_cnt++;
                last_ta  = take_action;
                last_tna = take_no_action;
                last_ch  = cmd_ch;
                last_jdo = jdo;
                if (model_q.size() == 0) begin
                    chk("unexpected_cmd", 1, 0);
                end else begin
                    m_e = model_q.pop_front();
                    chk("sb_ch", 64'(cmd_ch), 64'(m_e.ch));
                    chk("sb_jdo", 64'(jdo), 64'(m_e.dr));
                    if (m_e.dr[35]) m_eta = 4'b0001 << m_e.ch;
                    else            m_etn = 4'b0001 << m_e.ch;
                end
            end
            chk("pulse_action", 64'(take_action), 64'(m_eta));
            chk("pulse_no_action", 64'(take_no_action), 64'(m_etn));
        end
    end

    initial begin
        logic [63:0] r;
        int          start;

        vecs[0] = '{ir: 2'd2, sr: 38'h08_0000_1234, ta: 4'b0100, tna: 4'b0000};
        vecs[1] = '{ir: 2'd1, sr: 38'h00_0000_5678, ta: 4'b0000, tna: 4'b0010};
        vecs[2] = '{ir: 2'd3, sr: 38'h3F_FFFF_FFFF, ta: 4'b1000, tna: 4'b0000};
        vecs[3] = '{ir: 2'd0, sr: 38'h37_FFFF_FFFF, ta: 4'b0000, tna: 4'b0001};
        vecs[4] = '{ir: 2'd0, sr: 38'h08_0000_0000, ta: 4'b0001, tna: 4'b0000};
        vecs[5] = '{ir: 2'd3, sr: 38'h00_0000_0000, ta: 4'b0000, tna: 4'b1000};

        step(3);
        reset = 1'b0;
        chk("rst_valid", 64'(cmd_valid), 0);
        chk("rst_ch", 64'(cmd_ch), 0);
        chk("rst_jdo", 64'(jdo), 0);
        chk("rst_ta", 64'(take_action), 0);
        chk("rst_tna", 64'(take_no_action), 0);
        chk("rst_level", 64'(fifo_level), 0);
        chk("rst_overflow", 64'(overflow), 0);
        mon_en = 1'b1;
        step(4);

        // Single command latency: cmd_valid first visible after the cycle-4 edge.
        cmd_ready = 1'b1;
        send_uir(2'd2);
        sr     = 38'h08_0000_1234;
        vs_udr = 1'b1;
        model_q.push_back('{ch: 2'd2, dr: sr});
        step(4);
        chk("lat_c3_valid", 64'(cmd_valid), 0);
        step(1);
        chk("lat_c4_valid", 64'(cmd_valid), 1);
        chk("lat_c4_ch", 64'(cmd_ch), 2);
        chk("lat_c4_jdo", 64'(jdo), 64'h8_0000_1234);
        chk("lat_c4_ta", 64'(take_action), 4'b0100);
        chk("lat_c4_tna", 64'(take_no_action), 0);
        step(1);
        chk("lat_c5_valid", 64'(cmd_valid), 0);
        chk("lat_c5_ta", 64'(take_action), 0);
        chk("lat_c5_jdo_hold", 64'(jdo), 64'h8_0000_1234);
        vs_udr = 1'b0;
        step(4);

        for (int i = 0; i < 6; i++) begin
            send_uir(vecs[i].ir);
            start = acc_cnt;
            send_udr(vecs[i].sr, 1'b1, 0);
            for (int j = 0; j < 20 && acc_cnt == start; j++) step(1);
            chk("vec_accepted", 64'(acc_cnt - start), 1);
            chk("vec_ta", 64'(last_ta), 64'(vecs[i].ta));
            chk("vec_tna", 64'(last_tna), 64'(vecs[i].tna));
            chk("vec_ch", 64'(last_ch), 64'(vecs[i].ir));
            chk("vec_jdo", 64'(last_jdo), 64'(vecs[i].sr));
        end

        // Backpressure, full-with-pop, overflow set/clear.
        cmd_ready = 1'b0;
        send_uir(2'd1);
        for (int i = 1; i <= 5; i++) send_udr(38'h08_0000_0000 | 38'(i), 1'b1, 0);
        chk("bp_level4", 64'(fifo_level), 4);
        chk("bp_valid", 64'(cmd_valid), 1);
        chk("bp_head", 64'(jdo), 64'h8_0000_0001);
        chk("bp_no_overflow", 64'(overflow), 0);
        send_udr(38'h00_0000_0006, 1'b1, 1);
        chk("fullpop_level", 64'(fifo_level), 4);
        chk("fullpop_overflow", 64'(overflow), 0);
        chk("fullpop_head", 64'(jdo), 64'h8_0000_0002);
        send_udr(38'h00_0000_0007, 1'b0, 2);
        chk("drop_clr_setwins", 64'(overflow), 1);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        chk("clr_overflow", 64'(overflow), 0);
        send_udr(38'h00_0000_0008, 1'b0, 0);
        chk("drop_overflow", 64'(overflow), 1);
        chk("drop_level", 64'(fifo_level), 4);
        start = acc_cnt;
        cmd_ready = 1'b1;
        step(5);
        chk("b2b_accepts", 64'(acc_cnt - start), 5);
        chk("b2b_valid_low", 64'(cmd_valid), 0);
        chk("b2b_level0", 64'(fifo_level), 0);
        chk("b2b_empty_model", 64'(model_q.size()), 0);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;

        // Coincident IR and DR edges: push carries the old IR.
        send_uir(2'd0);
        ir_in  = 2'd3;
        sr     = 38'h08_0000_00AA;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        model_q.push_back('{ch: 2'd0, dr: sr});
        step(4);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        step(4);
        ir_model = 2'd3;
        chk("same_edge_old_ir", 64'(last_ch), 0);
        send_udr(38'h00_0000_00BB, 1'b1, 0);
        chk("same_edge_new_ir", 64'(last_ch), 3);

        // Reset release with vs_udr already high.
        reset  = 1'b1;
        vs_udr = 1'b1;
        step(3);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("rst_high_udr_valid", 64'(cmd_valid), 0);
        end
        vs_udr = 1'b0;
        step(4);
        chk("rst_high_udr_level", 64'(fifo_level), 0);

        // Reset in VALID with two queued.
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_udr(38'h08_0000_0100 + 38'(i), 1'b1, 0);
        chk("pre_rst_level", 64'(fifo_level), 2);
        chk("pre_rst_valid", 64'(cmd_valid), 1);
        reset     = 1'b1;
        cmd_ready = 1'b1;
        model_q.delete();
        step(1);
        reset = 1'b0;
        chk("midrst_valid", 64'(cmd_valid), 0);
        chk("midrst_jdo", 64'(jdo), 0);
        chk("midrst_ch", 64'(cmd_ch), 0);
        chk("midrst_level", 64'(fifo_level), 0);
        chk("midrst_overflow", 64'(overflow), 0);
        step(2);
        chk("midrst_after_valid", 64'(cmd_valid), 0);
        step(4);
        ir_model = '0;

        // Randomized traffic against the in-order queue model.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_uir(2'($urandom_range(0, 3)));
            end else begin
                r = {$urandom, $urandom};
                send_udr(r[37:0], 1'b1, 0);
            end
        end
        rand_ready = 1'b0;
        cmd_ready  = 1'b1;
        drain("rand_drain");
        chk("rand_no_overflow", 64'(overflow), 0);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
